seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_slot_timer.sv | 65 ++++++
 rtl/seg7_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, scan state type and anode helper for the 4-digit 7-segment scan controller.
package seg7_pkg;

    localparam int         SEG7_DIGITS       = 4;
    localparam logic [3:0] SEG7_BLANK_NIBBLE = 4'hF;
    localparam logic [3:0] SEG7_AN_OFF       = 4'b1111;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } seg7_state_e;

    // Active-low one-hot anode enable for the selected digit.
    function automatic logic [3:0] seg7_anode(input logic [1:0] sel);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << sel;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot counter, digit select and GUARD/SHOW state. Exposes next-cycle values so the
// parent can register its outputs in step with the counter.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] sel,
    output logic [1:0] sel_nxt,
    output logic       show_nxt,
    output logic       slot_end_nxt
);

    localparam int            CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    seg7_state_e   state;
    seg7_state_e   state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            sel   <= 2'd0;
            state <= GUARD;
        end else begin
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        state_nxt = state;
        if (!en) begin
            cnt_nxt   = '0;
            sel_nxt   = 2'd0;
            state_nxt = GUARD;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            sel_nxt   = sel + 2'd1;
            state_nxt = (BLANK_CYCLES == 0) ? SHOW : GUARD;
        end else begin
            cnt_nxt = cnt + 1'b1;
            if (state == GUARD && cnt_nxt >= CNT_SHOW) begin
                state_nxt = SHOW;
            end
        end
        show_nxt     = (state_nxt == SHOW);
        slot_end_nxt = (cnt_nxt == CNT_LAST);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with frame-aligned double buffering.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  digit,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic        load_ack
);

    logic [1:0]  sel_nxt;
    logic        show_nxt;
    logic        slot_end_nxt;
    logic        frame_tick_nxt;
    logic [15:0] shadow;
    logic [15:0] shadow_nxt;
    logic [15:0] pending;
    logic        pending_valid;
    logic        pending_valid_nxt;
    logic [3:0]  blank_eff;
    logic [3:0]  nibble_nxt;

    seg7_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sel          (sel),
        .sel_nxt      (sel_nxt),
        .show_nxt     (show_nxt),
        .slot_end_nxt (slot_end_nxt)
    );

    // load_ack is high exactly in the cycle the commit happens, so it doubles as the commit strobe.
    assign frame_tick_nxt    = slot_end_nxt && (sel_nxt == 2'(SEG7_DIGITS - 1));
    assign pending_valid_nxt = load || (pending_valid && !load_ack);
    assign shadow_nxt        = load_ack ? pending : shadow;
    assign nibble_nxt        = shadow_nxt[{sel_nxt, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic [3:0] lz_mask;

    always_comb begin
        lz_mask    = 4'b0000;
        lz_mask[3] = (shadow_nxt[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (shadow_nxt[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (shadow_nxt[7:4] == 4'h0);
    end

    assign blank_eff = blank_mask | lz_mask;
`else
    assign blank_eff = blank_mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow        <= 16'hFFFF;
            pending       <= 16'hFFFF;
            pending_valid <= 1'b0;
        end else begin
            shadow        <= shadow_nxt;
            pending_valid <= pending_valid_nxt;
            if (load) begin
                pending <= value;
            end
        end
    end

    // NOTE: outputs are registered from the timer's next-state values, so in any
    // cycle an/digit/frame_tick describe the same slot position that sel reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit      <= SEG7_BLANK_NIBBLE;
            an         <= SEG7_AN_OFF;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            frame_tick <= frame_tick_nxt;
            load_ack   <= frame_tick_nxt && pending_valid_nxt;
            an         <= show_nxt ? seg7_anode(sel_nxt) : SEG7_AN_OFF;
            if (!en || blank_eff[sel_nxt]) begin
                digit <= SEG7_BLANK_NIBBLE;
            end else begin
                digit <= nibble_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;
    localparam int LAST  = FRAME - 1;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [3:0] MASK_0042 = 4'b1100;
`else
    localparam logic [3:0] MASK_0042 = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  digit;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic        frame_tick;
    logic        load_ack;

    int checks = 0;
    int errors = 0;
    int v = 0;

    seg7_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .digit      (digit),
        .sel        (sel),
        .an         (an),
        .frame_tick (frame_tick),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        v++;
    endtask

    function automatic int pos();
        return v % FRAME;
    endfunction

    function automatic logic [3:0] exp_an();
        int p;
        logic [3:0] one;
        p   = v % FRAME;
        one = 4'b0001 << (p / RD);
        return ((p % RD) < BL) ? 4'b1111 : ~one;
    endfunction

    function automatic logic [1:0] exp_sel();
        return 2'((v % FRAME) / RD);
    endfunction

    function automatic logic [3:0] exp_dig(input logic [15:0] sh, input logic [3:0] mask);
        int s;
        s = (v % FRAME) / RD;
        return mask[s] ? 4'hF : sh[4*s +: 4];
    endfunction

    task automatic goto_pos(input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (pos() != p && n < FRAME);
    endtask

    task automatic do_load(input logic [15:0] val);
        value = val;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; blank_mask = 4'b0;
        step();
        step();
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (digit !== 4'hF) begin errors++; $display("FAIL reset_digit got %h exp f", digit); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_load_ack got %b exp 0", load_ack); end
        rst = 1'b0;
        en  = 1'b1;
        v   = 0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 40; i++) begin
            step();
            checks++; if (an !== exp_an()) begin errors++; $display("FAIL scan_an v=%0d got %b exp %b", v, an, exp_an()); end
            checks++; if (sel !== exp_sel()) begin errors++; $display("FAIL scan_sel v=%0d got %0d exp %0d", v, sel, exp_sel()); end
            checks++; if (digit !== 4'hF) begin errors++; $display("FAIL scan_digit v=%0d got %h exp f", v, digit); end
            checks++; if (frame_tick !== 1'(pos() == LAST)) begin errors++; $display("FAIL scan_frame_tick v=%0d got %b exp %b", v, frame_tick, pos() == LAST); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL scan_load_ack v=%0d got %b exp 0", v, load_ack); end
        end
    endtask

    task automatic test_load_commit();
        goto_pos(11);
        do_load(16'h1234);
        do begin
            step();
            checks++; if (digit !== 4'hF) begin errors++; $display("FAIL hold_digit v=%0d got %h exp f", v, digit); end
            checks++; if (load_ack !== 1'(pos() == LAST)) begin errors++; $display("FAIL commit_ack v=%0d got %b exp %b", v, load_ack, pos() == LAST); end
            checks++; if (frame_tick !== 1'(pos() == LAST)) begin errors++; $display("FAIL commit_tick v=%0d got %b exp %b", v, frame_tick, pos() == LAST); end
        end while (pos() != LAST);
        do begin
            step();
            checks++; if (digit !== exp_dig(16'h1234, 4'b0)) begin errors++; $display("FAIL show1234_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h1234, 4'b0)); end
            checks++; if (an !== exp_an()) begin errors++; $display("FAIL show1234_an v=%0d got %b exp %b", v, an, exp_an()); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL show1234_ack v=%0d got %b exp 0", v, load_ack); end
        end while (pos() != LAST);
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        goto_pos(5);
        do_load(16'hAAAA);
        goto_pos(20);
        do_load(16'h5555);
        do begin
            step();
            if (load_ack === 1'b1) acks++;
            checks++; if (digit !== exp_dig(16'h1234, 4'b0)) begin errors++; $display("FAIL b2b_old_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h1234, 4'b0)); end
        end while (pos() != LAST);
        do begin
            step();
            if (load_ack === 1'b1) acks++;
            checks++; if (digit !== exp_dig(16'h5555, 4'b0)) begin errors++; $display("FAIL b2b_new_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h5555, 4'b0)); end
        end while (pos() != LAST);
        checks++; if (acks != 1) begin errors++; $display("FAIL b2b_ack_count got %0d exp 1", acks); end
    endtask

    task automatic test_load_at_tick();
        goto_pos(10);
        do_load(16'hCCCC);
        do begin
            step();
        end while (pos() != LAST);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_load_tick got %b exp 1", frame_tick); end
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL tick_load_ack got %b exp 1", load_ack); end
        do_load(16'h9876);
        checks++; if (digit !== 4'hC) begin errors++; $display("FAIL tick_load_first_digit got %h exp c", digit); end
        do begin
            step();
            checks++; if (digit !== exp_dig(16'hCCCC, 4'b0)) begin errors++; $display("FAIL tick_cccc_digit v=%0d got %h exp %h", v, digit, exp_dig(16'hCCCC, 4'b0)); end
            checks++; if (load_ack !== 1'(pos() == LAST)) begin errors++; $display("FAIL tick_second_ack v=%0d got %b exp %b", v, load_ack, pos() == LAST); end
        end while (pos() != LAST);
        do begin
            step();
            checks++; if (digit !== exp_dig(16'h9876, 4'b0)) begin errors++; $display("FAIL tick_9876_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h9876, 4'b0)); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL tick_9876_ack v=%0d got %b exp 0", v, load_ack); end
        end while (pos() != LAST);
    endtask

    task automatic test_blank_and_reset();
        goto_pos(5);
        do_load(16'h1234);
        do begin
            step();
        end while (pos() != LAST);
        blank_mask = 4'b0100;
        do begin
            step();
            checks++; if (digit !== exp_dig(16'h1234, 4'b0100)) begin errors++; $display("FAIL mask_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h1234, 4'b0100)); end
            checks++; if (an !== exp_an()) begin errors++; $display("FAIL mask_an v=%0d got %b exp %b", v, an, exp_an()); end
        end while (pos() != LAST);
        goto_pos(12);
        do_load(16'h7777);
        goto_pos(20);
        rst = 1'b1;
        step();
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL midreset_an got %b exp 1111", an); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL midreset_sel got %0d exp 0", sel); end
        checks++; if (digit !== 4'hF) begin errors++; $display("FAIL midreset_digit got %h exp f", digit); end
        rst        = 1'b0;
        blank_mask = 4'b0;
        v          = 0;
        do begin
            step();
            checks++; if (digit !== 4'hF) begin errors++; $display("FAIL postreset_digit v=%0d got %h exp f", v, digit); end
            checks++; if (an !== exp_an()) begin errors++; $display("FAIL postreset_an v=%0d got %b exp %b", v, an, exp_an()); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL postreset_ack v=%0d got %b exp 0", v, load_ack); end
        end while (pos() != LAST);
    endtask

    task automatic test_enable();
        goto_pos(13);
        en = 1'b0;
        do_load(16'h0042);
        for (int i = 0; i < 40; i++) begin
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL dark_an i=%0d got %b exp 1111", i, an); end
            checks++; if (sel !== 2'd0) begin errors++; $display("FAIL dark_sel i=%0d got %0d exp 0", i, sel); end
            checks++; if (digit !== 4'hF) begin errors++; $display("FAIL dark_digit i=%0d got %h exp f", i, digit); end
            checks++; if (frame_tick !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL dark_pulses i=%0d got tick=%b ack=%b exp 0 0", i, frame_tick, load_ack); end
            step();
        end
        en = 1'b1;
        v  = 0;
        do begin
            step();
            checks++; if (an !== exp_an()) begin errors++; $display("FAIL restart_an v=%0d got %b exp %b", v, an, exp_an()); end
            checks++; if (sel !== exp_sel()) begin errors++; $display("FAIL restart_sel v=%0d got %0d exp %0d", v, sel, exp_sel()); end
            checks++; if (load_ack !== 1'(pos() == LAST)) begin errors++; $display("FAIL restart_ack v=%0d got %b exp %b", v, load_ack, pos() == LAST); end
        end while (pos() != LAST);
        do begin
            step();
            checks++; if (digit !== exp_dig(16'h0042, MASK_0042)) begin errors++; $display("FAIL show0042_digit v=%0d got %h exp %h", v, digit, exp_dig(16'h0042, MASK_0042)); end
        end while (pos() != LAST);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_commit();
        test_back_to_back();
        test_load_at_tick();
        test_blank_and_reset();
        test_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
